// File: rtl/dff_deser_pkg.sv
// Purpose : shared types and helpers for the dff_deser serial-to-parallel block.
// Latency : n/a (types, constants and a width helper only).
// Backpr. : n/a.
package dff_deser_pkg;

  // Input assembly FSM: idle between words, shifting while a word is partial.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_t;

  // Width of the bit counter for a word of `width` bits (counts 0..width-1).
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage : dff_deser_pkg

// File: rtl/dff_deser_hold.sv
// Purpose : one-word valid/ready holding register with sticky overflow on dropped words.
// Latency : a completed word appears on dout/dout_vld one clock after word_vld.
// Backpr. : a word arriving while full and not being popped is dropped; overflow latches.
//
// Ports:
//   clk, rstn            clock and async active-low reset
//   word_vld, word_dat   completed word from the shifter (single-cycle strobe)
//   dout_rdy             consumer accepts dout when dout_vld && dout_rdy
//   clr_ovf              synchronous clear of the sticky overflow flag
//   dout, dout_vld       held word and its valid flag
//   overflow             sticky drop indicator
module dff_deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             word_vld,
  input  logic [WIDTH-1:0] word_dat,
  input  logic             dout_rdy,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             overflow
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             can_load;
  logic             drop;

  always_comb begin
    pop      = vld_q && dout_rdy;
    // A pop in the same cycle frees the slot, so back-to-back words see no bubble.
    can_load = !vld_q || pop;
    drop     = word_vld && !can_load;

    dat_d = dat_q;
    vld_d = vld_q;
    if (word_vld && can_load) begin
      dat_d = word_dat;
      vld_d = 1'b1;
    end else if (pop) begin
      // dout keeps the last word after it is consumed; only the valid drops.
      vld_d = 1'b0;
    end

    // A new drop outranks a simultaneous clear.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout     = dat_q;
  assign dout_vld = vld_q;
  assign overflow = ovf_q;

endmodule : dff_deser_hold

// File: rtl/dff_deser.sv
// Purpose : packs the registered serial stream of the d_ff stage into WIDTH-bit words.
// Latency : last bit sampled at edge N -> word valid on dout after edge N.
// Backpr. : one-word holding register; a word completing while it is full and unpopped is dropped (sticky overflow).
//
// Ports:
//   clk, rstn            clock and async active-low reset
//   din, din_vld         serial bit and its sample enable
//   flush                discard the partial word (wins over din_vld)
//   dout, dout_vld       assembled word / holding register valid
//   dout_rdy             consumer ready
//   bit_cnt              bits collected in the current partial word
//   overflow, clr_ovf    sticky drop flag and its synchronous clear
module dff_deser
  import dff_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             din_vld,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overflow,
  input  logic             clr_ovf
);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] sh_word;
  logic             word_done;

  // Shift register after taking in din this cycle. LSB-first enters at the top
  // and shifts right; MSB-first enters at the bottom and shifts left, so after
  // WIDTH bits the first bit sits in bit 0 or bit WIDTH-1 respectively.
  always_comb begin
    if (MSB_FIRST) begin
      sh_word = {sreg_q[WIDTH-2:0], din};
    end else begin
      sh_word = {din, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    word_done = 1'b0;

    if (flush) begin
      // Flush outranks a valid bit, even the completing one: nothing is emitted.
      state_d = ST_IDLE;
      cnt_d   = '0;
      sreg_d  = '0;
    end else if (din_vld) begin
      sreg_d = sh_word;
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SHIFT;
          cnt_d   = CW'(1);
        end
        ST_SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  assign bit_cnt = cnt_q;

  // The completed word is taken from the combinational shift result so it can
  // load the holding register on the same edge that samples the last bit.
  dff_deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk      (clk),
    .rstn     (rstn),
    .word_vld (word_done),
    .word_dat (sh_word),
    .dout_rdy (dout_rdy),
    .clr_ovf  (clr_ovf),
    .dout     (dout),
    .dout_vld (dout_vld),
    .overflow (overflow)
  );

endmodule : dff_deser

// File: tb/tb_dff_deser.sv
module tb_dff_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         din = 1'b0;
  logic         din_vld = 1'b0;
  logic         flush = 1'b0;
  logic         dout_rdy = 1'b0;
  logic         clr_ovf = 1'b0;

  logic [W-1:0] dout_l, dout_m;
  logic         vld_l, vld_m;
  logic [2:0]   cnt_l, cnt_m;
  logic         ovf_l, ovf_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .flush(flush),
    .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy), .bit_cnt(cnt_l),
    .overflow(ovf_l), .clr_ovf(clr_ovf)
  );

  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .flush(flush),
    .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy), .bit_cnt(cnt_m),
    .overflow(ovf_m), .clr_ovf(clr_ovf)
  );

  // Reference model: received bits kept in arrival order, one pending word.
  bit           mq[$];
  logic [W-1:0] m_lsb, m_msb;
  logic         m_vld, m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lsb = '0;
    m_msb = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Applies the rules for one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    logic         done, pop, drop;
    logic [W-1:0] w_lsb, w_msb;
    done  = 1'b0;
    drop  = 1'b0;
    w_lsb = '0;
    w_msb = '0;
    pop   = m_vld && dout_rdy;
    if (flush) begin
      mq.delete();
    end else if (din_vld) begin
      mq.push_back(din);
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) begin
          w_lsb[i]       = mq[i];
          w_msb[W-1-i]   = mq[i];
        end
        mq.delete();
        done = 1'b1;
      end
    end
    if (done && (!m_vld || pop)) begin
      m_lsb = w_lsb;
      m_msb = w_msb;
      m_vld = 1'b1;
    end else if (done) begin
      drop = 1'b1;
    end else if (pop) begin
      m_vld = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    check("dout_lsb", 32'(dout_l), 32'(m_lsb));
    check("dout_msb", 32'(dout_m), 32'(m_msb));
    check("vld_lsb", 32'(vld_l), 32'(m_vld));
    check("vld_msb", 32'(vld_m), 32'(m_vld));
    check("cnt_lsb", 32'(cnt_l), 32'(mq.size()));
    check("cnt_msb", 32'(cnt_m), 32'(mq.size()));
    check("ovf_lsb", 32'(ovf_l), 32'(m_ovf));
    check("ovf_msb", 32'(ovf_m), 32'(m_ovf));
  endtask

  // One clock: inputs already driven; update model at the edge, compare after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // Sends the low n bits of b, bit 0 first, with din_vld held high.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      din     = b[i];
      din_vld = 1'b1;
      step();
    end
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_dout", 32'(dout_l), 32'h0);
    check("rst_vld", 32'(vld_l), 32'h0);
    check("rst_cnt", 32'(cnt_l), 32'h0);
    check("rst_ovf", 32'(ovf_l), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: continuous stream, consumer always ready.
    dout_rdy = 1'b1;
    send_bits(8'h4D, 8);
    check("t1_dout_lsb", 32'(dout_l), 32'h4D);
    check("t1_dout_msb", 32'(dout_m), 32'hB2);
    check("t1_vld", 32'(vld_l), 32'h1);
    check("t1_cnt", 32'(cnt_l), 32'h0);
    idle(1);
    check("t1_vld_one_cycle", 32'(vld_l), 32'h0);
    check("t1_dout_held", 32'(dout_l), 32'h4D);

    // 2: gap mid-word.
    send_bits(8'h4D, 4);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t2_cnt_gap", 32'(cnt_l), 32'h4);
    end
    send_bits(8'h4D >> 4, 4);
    check("t2_dout", 32'(dout_l), 32'h4D);
    check("t2_vld", 32'(vld_l), 32'h1);
    idle(1);

    // 3: backpressure -> drop -> clear -> drain.
    dout_rdy = 1'b0;
    send_bits(8'h4D, 8);
    send_bits(8'hFF, 8);
    check("t3_dout", 32'(dout_l), 32'h4D);
    check("t3_vld", 32'(vld_l), 32'h1);
    check("t3_ovf", 32'(ovf_l), 32'h1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", 32'(ovf_l), 32'h0);
    dout_rdy = 1'b1;
    idle(1);
    check("t3_drain", 32'(vld_l), 32'h0);

    // 4: pop coincides with completion.
    dout_rdy = 1'b0;
    send_bits(8'h4D, 8);
    send_bits(8'hA5, 7);
    dout_rdy = 1'b1;
    din = 1'b1;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    check("t4_dout", 32'(dout_l), 32'hA5);
    check("t4_vld", 32'(vld_l), 32'h1);
    check("t4_ovf", 32'(ovf_l), 32'h0);
    dout_rdy = 1'b1;
    idle(1);

    // 5: flush mid-word, then on the completing bit.
    send_bits(8'hFF, 5);
    din = 1'b1; din_vld = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; din_vld = 1'b0;
    check("t5_flush_cnt", 32'(cnt_l), 32'h0);
    send_bits(8'h3C, 8);
    check("t5_dout", 32'(dout_l), 32'h3C);
    idle(1);
    send_bits(8'hFF, 7);
    din = 1'b1; din_vld = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; din_vld = 1'b0;
    check("t5_flush_last_vld", 32'(vld_l), 32'h0);
    check("t5_flush_last_ovf", 32'(ovf_l), 32'h0);
    check("t5_flush_last_cnt", 32'(cnt_l), 32'h0);

    // 6: async reset with a pending word, overflow and a partial word.
    dout_rdy = 1'b0;
    send_bits(8'h4D, 8);
    send_bits(8'h11, 8);
    send_bits(8'h07, 3);
    check("t6_pre_cnt", 32'(cnt_l), 32'h3);
    check("t6_pre_vld", 32'(vld_l), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_vld", 32'(vld_l), 32'h0);
    check("t6_rst_cnt", 32'(cnt_l), 32'h0);
    check("t6_rst_ovf", 32'(ovf_l), 32'h0);
    check("t6_rst_dout", 32'(dout_l), 32'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    dout_rdy = 1'b1;
    send_bits(8'h4D, 8);
    check("t6_after_dout", 32'(dout_l), 32'h4D);
    check("t6_after_vld", 32'(vld_l), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      din      = 1'($urandom_range(0, 1));
      din_vld  = ($urandom_range(0, 99) < 70);
      flush    = ($urandom_range(0, 99) < 3);
      dout_rdy = ($urandom_range(0, 99) < 45);
      clr_ovf  = ($urandom_range(0, 99) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dff_deser
